// File: rtl/lab_readout_pkg.sv
// lab_readout_pkg: shared types and helpers for the LAB readout arbiter.
//   state_e   - arbiter FSM states
//   HdrPad    - fixed pad byte between tag and channel in the header word
//   clog2()   - ceiling log2 used to size address/select ports
//   hdr_word()- builds the 32-bit channel header {tag, pad, channel}
package lab_readout_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StRead,
      StDrain,
      StFin
   } state_e;

   localparam logic [7:0] HdrPad = 8'h00;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic [31:0] hdr_word(input logic [15:0] tag, input logic [7:0] ch);
      return {tag, HdrPad, ch};
   endfunction

endpackage

// File: rtl/lab_skid_fifo.sv
// lab_skid_fifo: 2-entry FIFO absorbing RAM read data while the stream is stalled.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i: write one entry (ignored only if full with no pop)
//   pop_i        : consume head entry (ignored when empty)
//   data_o/valid_o: head entry and non-empty flag
//   count_o      : current occupancy (0..2)
module lab_skid_fifo #(
   parameter int unsigned W = 33
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   cnt_q;
   logic         do_push, do_pop;

   assign do_pop  = pop_i & (cnt_q != 2'd0);
   assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (do_push) wr_q <= ~wr_q;
         if (do_pop)  rd_q <= ~rd_q;
         cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign valid_o = (cnt_q != 2'd0);
   assign count_o = cnt_q;

endmodule

// File: rtl/lab_readout_arb.sv
// lab_readout_arb: round-robin streamer of per-channel LAB RAM contents.
//   digitize_i/readout_done_i/mask_i : per-channel control pulses and stream mask
//   ram_sel_o/ram_addr_o/ram_dat_i   : shared RAM read port, 1-cycle latency
//   m_dat_o/m_valid_o/m_ready_i/m_last_o : output stream (header + NWORDS words)
//   done_o, busy_o, event_done_o     : status
module lab_readout_arb
   import lab_readout_pkg::*;
#(
   parameter int unsigned  NLAB    = 4,
   parameter int unsigned  NWORDS  = 1536,
   parameter int unsigned  DW      = 32,
   parameter logic [15:0]  HDR_TAG = 16'hA5A5,
   localparam int unsigned AW      = clog2(NWORDS),
   localparam int unsigned CW      = (clog2(NLAB) > 0) ? clog2(NLAB) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NLAB-1:0]  digitize_i,
   input  logic [NLAB-1:0]  readout_done_i,
   input  logic [NLAB-1:0]  mask_i,
   output logic [CW-1:0]    ram_sel_o,
   output logic [AW-1:0]    ram_addr_o,
   input  logic [NLAB*DW-1:0] ram_dat_i,
   output logic [DW-1:0]    m_dat_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             m_last_o,
   output logic [NLAB-1:0]  done_o,
   output logic             busy_o,
   output logic             event_done_o
);

   localparam logic [AW-1:0] LastAddr = AW'(NWORDS - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   sel_q, sel_d, last_q, last_d, pick;
   logic [AW-1:0]   addr_q, addr_d;
   logic [NLAB-1:0] done_q, pend_q, pend_d, hdr_clr;
   logic            inflight_q, inflight_last_q;
   logic            issue, hdr_acc, data_phase, fifo_valid, fifo_pop;
   logic [1:0]      fifo_cnt;
   logic [DW:0]     fifo_dat;
   logic [2:0]      load;
   logic [DW-1:0]   ram_word;

   assign data_phase = (state_q == StRead) || (state_q == StDrain);
   assign fifo_pop   = data_phase & fifo_valid & m_ready_i;
   // Occupancy after this cycle's pop plus the read already in flight.
   assign load       = 3'(fifo_cnt) - 3'(fifo_pop) + 3'(inflight_q);
   assign issue      = (state_q == StRead) && (load < 3'd2);
   assign ram_word   = ram_dat_i[32'(sel_q)*DW +: DW];
   assign hdr_clr    = hdr_acc ? (NLAB'(1) << sel_q) : '0;
   // Clear-then-set so a new readout_done during header acceptance is not lost.
   assign pend_d     = (pend_q & ~hdr_clr) | (readout_done_i & ~mask_i & ~digitize_i);

   // Round-robin: first pending channel after the one served last.
   always_comb begin
      logic        found;
      int unsigned idx;
      pick  = last_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 1; i <= NLAB; i++) begin
         idx = (32'(last_q) + i) % NLAB;
         if (!found && ((pend_q >> idx) & NLAB'(1)) != '0) begin
            found = 1'b1;
            pick  = CW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      addr_d       = addr_q;
      hdr_acc      = 1'b0;
      event_done_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|pend_q) begin
               state_d = StHdr;
               sel_d   = pick;
               last_d  = pick;
               addr_d  = '0;
            end
         end
         StHdr: begin
            if (m_ready_i) begin
               hdr_acc = 1'b1;
               state_d = StRead;
            end
         end
         StRead: begin
            if (issue) begin
               addr_d = addr_q + AW'(1);
               if (addr_q == LastAddr) begin
                  addr_d  = '0;
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (load == 3'd0) state_d = StFin;
         end
         StFin: begin
            if (|pend_q) begin
               state_d = StHdr;
               sel_d   = pick;
               last_d  = pick;
               addr_d  = '0;
            end else begin
               state_d      = StIdle;
               event_done_o = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= StIdle;
         sel_q           <= '0;
         last_q          <= CW'(NLAB - 1);
         addr_q          <= '0;
         done_q          <= '0;
         pend_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         sel_q           <= sel_d;
         last_q          <= last_d;
         addr_q          <= addr_d;
         done_q          <= (done_q | readout_done_i) & ~digitize_i;
         pend_q          <= pend_d;
         inflight_q      <= issue;
         inflight_last_q <= issue & (addr_q == LastAddr);
      end
   end

   lab_skid_fifo #(
      .W(DW + 1)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (inflight_q),
      .data_i  ({inflight_last_q, ram_word}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dat),
      .valid_o (fifo_valid),
      .count_o (fifo_cnt)
   );

   assign ram_sel_o  = sel_q;
   assign ram_addr_o = addr_q;
   assign m_valid_o  = (state_q == StHdr) | (data_phase & fifo_valid);
   assign m_dat_o    = (state_q == StHdr) ? DW'(hdr_word(HDR_TAG, 8'(sel_q))) : fifo_dat[DW-1:0];
   assign m_last_o   = data_phase & fifo_valid & fifo_dat[DW];
   assign done_o     = done_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_lab_readout_arb.sv
// tb_lab_readout_arb: table-driven scenarios with a stream scoreboard for lab_readout_arb.
module tb_lab_readout_arb;

   localparam int unsigned NLAB = 4;
   localparam int unsigned NWORDS = 8;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    digitize, rdone, mask, done;
   logic [1:0]    ram_sel;
   logic [2:0]    ram_addr;
   logic [127:0]  ram_dat;
   logic [31:0]   m_dat;
   logic          m_valid, m_ready, m_last, busy, ev;

   int n_pass = 0, n_chk = 0;
   int ev_count = 0, ev_cyc = -1, last_cyc = -100, hs_cnt = 0, cyc = 0;
   bit tog = 1'b0;
   logic [32:0] sb[$];

   typedef struct {
      logic [3:0] rdone;
      logic [3:0] dig;
      logic [3:0] mask;
      bit         tog;
      logic [3:0] exp_done;
      int         n_ch;
      logic [7:0] order;  // channel i of the expected order at [2*i +: 2]
   } vec_t;

   always #5 clk = ~clk;

   lab_readout_arb #(
      .NLAB   (NLAB),
      .NWORDS (NWORDS),
      .DW     (DW),
      .HDR_TAG(16'hA5A5)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .digitize_i    (digitize),
      .readout_done_i(rdone),
      .mask_i        (mask),
      .ram_sel_o     (ram_sel),
      .ram_addr_o    (ram_addr),
      .ram_dat_i     (ram_dat),
      .m_dat_o       (m_dat),
      .m_valid_o     (m_valid),
      .m_ready_i     (m_ready),
      .m_last_o      (m_last),
      .done_o        (done),
      .busy_o        (busy),
      .event_done_o  (ev)
   );

   function automatic logic [31:0] ram_val(input int k, input int a);
      return 32'hDA70_0000 | (32'(k) << 8) | 32'(a);
   endfunction

   // Channel RAMs with 1-cycle read latency.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) ram_dat[k*32 +: 32] <= ram_val(k, int'(ram_addr));
   end

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_chan(input int ch);
      sb.push_back({1'b0, 32'hA5A5_0000 | 32'(ch)});
      for (int a = 0; a < 8; a++) sb.push_back({(a == 7), ram_val(ch, a)});
   endtask

   task automatic pulse(input logic [3:0] rd, input logic [3:0] dg, input logic [3:0] mk);
      @(posedge clk); #1;
      rdone = rd; digitize = dg; mask = mk;
      @(posedge clk); #1;
      rdone = '0; digitize = '0; mask = '0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      repeat (4) @(posedge clk);
      while ((sb.size() != 0 || busy) && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 2000) check("idle_timeout", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   // Ready pattern: constant 1, or 1,0,0,1 repeating.
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (tog) begin
            m_ready = pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            m_ready = 1'b1;
         end
      end
   end

   // Stream monitor: scoreboard compare on handshake, stability while stalled.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_dat;
      logic [32:0] e;
      prev_stall = 1'b0;
      prev_dat = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (ev) begin
               ev_count++;
               ev_cyc = cyc;
            end
            if (prev_stall) begin
               check("stall_valid", 64'(m_valid), 64'd1);
               check("stall_data", 64'(m_dat), 64'(prev_dat));
            end
            if (m_valid && m_ready) begin
               hs_cnt++;
               if (sb.size() == 0) begin
                  check("unexpected_word", 64'(m_valid), 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("stream_word", 64'({m_last, m_dat}), 64'(e));
                  if (m_last) last_cyc = cyc;
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_dat = m_dat;
         end
      end
   end

   initial begin
      vec_t tbl[6];
      int h0, t;
      tbl[0] = '{rdone:4'b0001, dig:4'b0000, mask:4'b0000, tog:1'b0, exp_done:4'b0001,
                 n_ch:1, order:8'h00};
      tbl[1] = '{rdone:4'b1010, dig:4'b0000, mask:4'b0000, tog:1'b0, exp_done:4'b1010,
                 n_ch:2, order:8'h0D};
      tbl[2] = '{rdone:4'b0100, dig:4'b0000, mask:4'b0000, tog:1'b1, exp_done:4'b0100,
                 n_ch:1, order:8'h02};
      tbl[3] = '{rdone:4'b0100, dig:4'b0100, mask:4'b0000, tog:1'b0, exp_done:4'b0000,
                 n_ch:0, order:8'h00};
      tbl[4] = '{rdone:4'b0010, dig:4'b0000, mask:4'b0010, tog:1'b0, exp_done:4'b0010,
                 n_ch:0, order:8'h00};
      tbl[5] = '{rdone:4'b1111, dig:4'b0000, mask:4'b0000, tog:1'b1, exp_done:4'b1111,
                 n_ch:4, order:8'h93};

      rst = 1'b1; digitize = '0; rdone = '0; mask = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_last", 64'(m_last), 64'd0);
      check("rst_event", 64'(ev), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_addr", 64'(ram_addr), 64'd0);
      check("rst_sel", 64'(ram_sel), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int r = 0; r < 6; r++) begin
         tog = tbl[r].tog;
         pulse(4'b0000, 4'b1111, 4'b0000);
         ev_count = 0; ev_cyc = -1; last_cyc = -100;
         for (int i = 0; i < tbl[r].n_ch; i++) push_chan(int'(tbl[r].order[2*i +: 2]));
         pulse(tbl[r].rdone, tbl[r].dig, tbl[r].mask);
         wait_idle();
         check($sformatf("row%0d_done", r), 64'(done), 64'(tbl[r].exp_done));
         check($sformatf("row%0d_busy", r), 64'(busy), 64'd0);
         check($sformatf("row%0d_sb_empty", r), 64'(sb.size()), 64'd0);
         check($sformatf("row%0d_events", r), 64'(ev_count), 64'(tbl[r].n_ch > 0));
         if (tbl[r].n_ch > 0)
            check($sformatf("row%0d_event_timing", r), 64'(ev_cyc), 64'(last_cyc + 1));
      end

      // Reset while data word 4 of channel 0 is on the stream.
      tog = 1'b0;
      sb.delete();
      push_chan(0);
      h0 = hs_cnt;
      pulse(4'b0001, 4'b0000, 4'b0000);
      t = 0;
      while (hs_cnt < h0 + 5 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) check("rst_wait_timeout", 64'(hs_cnt - h0), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", 64'(m_valid), 64'd0);
      check("midrst_last", 64'(m_last), 64'd0);
      check("midrst_event", 64'(ev), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_addr", 64'(ram_addr), 64'd0);
      check("midrst_sel", 64'(ram_sel), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      ev_count = 0; ev_cyc = -1; last_cyc = -100;
      push_chan(0);
      pulse(4'b0001, 4'b0000, 4'b0000);
      wait_idle();
      check("post_rst_done", 64'(done), 64'd1);
      check("post_rst_sb_empty", 64'(sb.size()), 64'd0);
      check("post_rst_events", 64'(ev_count), 64'd1);
      check("post_rst_event_timing", 64'(ev_cyc), 64'(last_cyc + 1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
